// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the RV32I pipeline.
// The master modport belongs to the control unit. The slave modport belongs to the datapath side.
interface pipe_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_ren_i;
  logic        id_rs2_ren_i;
  logic        ex_busy_req_i;
  logic        ex_busy_done_i;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_stall_o;
  logic        id_ex_flush_o;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        busy_timeout_o;
  logic [31:0] stall_cnt_o;

  modport master (
    input  jump_en_i, jump_addr_i, ex_mem_read_i, ex_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rs1_ren_i, id_rs2_ren_i,
           ex_busy_req_i, ex_busy_done_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
           id_ex_flush_o, jump_en_o, jump_addr_o, busy_timeout_o, stall_cnt_o
  );

  modport slave (
    output jump_en_i, jump_addr_i, ex_mem_read_i, ex_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rs1_ren_i, id_rs2_ren_i,
           ex_busy_req_i, ex_busy_done_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
           id_ex_flush_o, jump_en_o, jump_addr_o, busy_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush control for the five-stage core: redirects, load-use bubbles, multi-cycle EX ops.
// Defining PIPE_CTRL_BUSY_TIMEOUT_EN compiles in the BUSY watchdog and the sticky TRAP state.
module pipe_ctrl #(
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        lu;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_flush;
  logic        jump_en;
  logic        timeout_flag;
  logic [31:0] stall_cnt_q;

`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic [15:0] tmo_d;
`else
  logic [15:0] unused_busy_timeout;
  assign unused_busy_timeout = 16'(BUSY_TIMEOUT);
`endif

  always_comb begin
    lu = bus.ex_mem_read_i && (bus.ex_rd_addr_i != 5'd0) &&
         ((bus.id_rs1_ren_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
          (bus.id_rs2_ren_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));
  end

  // Jump beats multi-cycle start, which beats load-use; BUSY and TRAP only ever stall.
  always_comb begin
    state_d      = state_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    jump_en      = 1'b0;
    timeout_flag = 1'b0;
`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.jump_en_i) begin
          jump_en     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.ex_busy_req_i && !bus.ex_busy_done_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          state_d     = BUSY;
`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
          tmo_d       = 16'd1;
`endif
        end else if (lu) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      BUSY: begin
        if (bus.ex_busy_done_i) begin
          state_d = IDLE;
        end else begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
          tmo_d       = tmo_q + 16'd1;
          if (tmo_q == 16'(BUSY_TIMEOUT)) begin
            state_d = TRAP;
          end
`endif
        end
      end
      TRAP: begin
`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        timeout_flag = 1'b1;
`else
        state_d      = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The stall counter sees the ungated strobe; reset takes precedence over it anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      stall_cnt_q <= 32'd0;
`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
      tmo_q       <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end

  assign bus.pc_stall_o     = rst & pc_stall;
  assign bus.if_id_stall_o  = rst & if_id_stall;
  assign bus.if_id_flush_o  = rst & if_id_flush;
  assign bus.id_ex_stall_o  = rst & id_ex_stall;
  assign bus.id_ex_flush_o  = rst & id_ex_flush;
  assign bus.jump_en_o      = rst & jump_en;
  assign bus.jump_addr_o    = (rst && jump_en) ? bus.jump_addr_i : 32'd0;
  assign bus.busy_timeout_o = rst & timeout_flag;
  assign bus.stall_cnt_o    = rst ? stall_cnt_q : 32'd0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver predicts each cycle from a behavioural model,
// and a monitor compares the DUT outputs against the queued predictions.
module tb_pipe_ctrl;

  localparam int unsigned TMO = 4;
`ifdef PIPE_CTRL_BUSY_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef struct {
    bit          rst;
    bit          jump_en;
    logic [31:0] jump_addr;
    bit          mem_read;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          ren1;
    bit          ren2;
    bit          req;
    bit          done;
  } stim_t;

  typedef struct {
    logic [6:0]  strobes;
    logic [31:0] jump_addr;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.BUSY_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          m_busy = 1'b0;
  bit          m_trap = 1'b0;
  int unsigned m_age  = 0;
  logic [31:0] m_cnt  = 32'd0;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1'b1; s.jump_en = 1'b0; s.jump_addr = 32'd0; s.mem_read = 1'b0;
    s.rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0; s.ren1 = 1'b0; s.ren2 = 1'b0;
    s.req = 1'b0; s.done = 1'b0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst       = ($urandom % 25) != 0;
    s.jump_en   = ($urandom % 6) == 0;
    s.jump_addr = $urandom;
    s.mem_read  = $urandom % 2;
    s.rd        = 5'($urandom % 4);
    s.rs1       = 5'($urandom % 4);
    s.rs2       = 5'($urandom % 4);
    s.ren1      = $urandom % 2;
    s.ren2      = $urandom % 2;
    s.req       = ($urandom % 5) == 0;
    s.done      = ($urandom % 3) == 0;
    return s;
  endfunction

  // Strobe order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, jump_en, busy_timeout
  task automatic applyStimulus(input stim_t s, input string tag);
    exp_t e;
    bit   hazard;
    bit   stall_all;
    @(negedge clk);
    rst               = s.rst;
    bus.jump_en_i     = s.jump_en;
    bus.jump_addr_i   = s.jump_addr;
    bus.ex_mem_read_i = s.mem_read;
    bus.ex_rd_addr_i  = s.rd;
    bus.id_rs1_addr_i = s.rs1;
    bus.id_rs2_addr_i = s.rs2;
    bus.id_rs1_ren_i  = s.ren1;
    bus.id_rs2_ren_i  = s.ren2;
    bus.ex_busy_req_i = s.req;
    bus.ex_busy_done_i = s.done;
    hazard = s.mem_read && (s.rd != 0) &&
             ((s.ren1 && s.rs1 == s.rd) || (s.ren2 && s.rs2 == s.rd));
    e.strobes = 7'b0; e.jump_addr = 32'd0; e.cnt = 32'd0; e.tag = tag;
    stall_all = 1'b0;
    if (s.rst) begin
      e.cnt = m_cnt;
      if (m_trap) begin
        e.strobes = 7'b1101001;
      end else if (m_busy) begin
        if (!s.done) e.strobes = 7'b1101000;
      end else if (s.jump_en) begin
        e.strobes   = 7'b0010110;
        e.jump_addr = s.jump_addr;
      end else if (s.req && !s.done) begin
        e.strobes = 7'b1101000;
        stall_all = 1'b1;
      end else if (hazard) begin
        e.strobes = 7'b1100100;
      end
    end
    #1 sb_q.push_back(e);
    @(posedge clk);
    if (!s.rst) begin
      m_busy = 1'b0; m_trap = 1'b0; m_age = 0; m_cnt = 32'd0;
    end else begin
      if (e.strobes[6] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_busy) begin
        if (s.done) m_busy = 1'b0;
        else if (TIMEOUT_ON && m_age == TMO) begin m_busy = 1'b0; m_trap = 1'b1; end
        else m_age = m_age + 1;
      end else if (stall_all) begin
        m_busy = 1'b1;
        m_age  = 1;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] act;
    act = {bus.pc_stall_o, bus.if_id_stall_o, bus.if_id_flush_o, bus.id_ex_stall_o,
           bus.id_ex_flush_o, bus.jump_en_o, bus.busy_timeout_o};
    n_vec++;
    if (act !== e.strobes || bus.jump_addr_o !== e.jump_addr || bus.stall_cnt_o !== e.cnt) begin
      n_bad++;
      $display("[TB] FAIL %s: got strobes=%b addr=%h cnt=%h, expected strobes=%b addr=%h cnt=%h",
               e.tag, act, bus.jump_addr_o, bus.stall_cnt_o, e.strobes, e.jump_addr, e.cnt);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    bus.jump_en_i = 0; bus.jump_addr_i = 0; bus.ex_mem_read_i = 0; bus.ex_rd_addr_i = 0;
    bus.id_rs1_addr_i = 0; bus.id_rs2_addr_i = 0; bus.id_rs1_ren_i = 0; bus.id_rs2_ren_i = 0;
    bus.ex_busy_req_i = 0; bus.ex_busy_done_i = 0;

    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.rst = 1'b0;
      applyStimulus(s, "reset_hold");
    end
    for (int i = 0; i < 3; i++) applyStimulus(idle_stim(), "post_reset_idle");

    s = idle_stim(); s.mem_read = 1; s.rd = 5; s.rs2 = 5; s.ren2 = 1; s.rs1 = 7; s.ren1 = 1;
    applyStimulus(s, "load_use");
    applyStimulus(idle_stim(), "load_use_after");
    s.rd = 0; s.rs2 = 0;
    applyStimulus(s, "load_use_x0");

    s = idle_stim(); s.jump_en = 1; s.jump_addr = 32'h0000_0100;
    s.mem_read = 1; s.rd = 3; s.rs1 = 3; s.ren1 = 1; s.req = 1;
    applyStimulus(s, "jump_over_lu");
    applyStimulus(idle_stim(), "jump_after");

    s = idle_stim(); s.req = 1;
    applyStimulus(s, "mc_request");
    for (int i = 0; i < 4; i++) begin
      s = idle_stim();
      if (i == 2) begin s.jump_en = 1; s.jump_addr = 32'hDEAD_BEE0; end
      applyStimulus(s, "mc_busy");
    end
    s = idle_stim(); s.done = 1;
    applyStimulus(s, "mc_done");
    applyStimulus(idle_stim(), "mc_after");

    s = idle_stim(); s.req = 1;
    applyStimulus(s, "tmo_request");
    for (int i = 0; i < 8; i++) applyStimulus(idle_stim(), "tmo_wait");
    s = idle_stim(); s.done = 1; s.jump_en = 1; s.jump_addr = 32'h40;
    applyStimulus(s, "tmo_done_late");
    applyStimulus(idle_stim(), "tmo_hold");
    s = idle_stim(); s.rst = 0;
    applyStimulus(s, "tmo_reset");
    applyStimulus(idle_stim(), "tmo_cleared");

    #1 force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    applyStimulus(idle_stim(), "sat_preload");
    s = idle_stim(); s.req = 1;
    applyStimulus(s, "sat_request");
    applyStimulus(idle_stim(), "sat_busy");
    applyStimulus(idle_stim(), "sat_busy");
    s = idle_stim(); s.done = 1;
    applyStimulus(s, "sat_done");
    applyStimulus(idle_stim(), "sat_hold");
    applyStimulus(idle_stim(), "sat_hold");

    for (int i = 0; i < 400; i++) applyStimulus(rand_stim(), "random");

    repeat (3) @(negedge clk);
    #6;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
